// File: rtl/wb_trace_pkg.sv
// wb_trace_pkg
//   Shared definitions for the writeback trace FIFO: default geometry
//   constants and the {register, data} entry layout used by the FIFO and
//   by anything that consumes its output stream.
package wb_trace_pkg;

  localparam int DEFAULT_DEPTH  = 8;
  localparam int DEFAULT_REG_W  = 6;
  localparam int DEFAULT_DATA_W = 32;

  // Saturation ceiling of the optional dropped-entry counter.
  localparam logic [15:0] OVF_CNT_MAX = 16'hFFFF;

  // One traced writeback event at the default geometry. The register index
  // sits in the upper bits so a packed entry matches {regIn, dataIn}.
  typedef struct packed {
    logic [DEFAULT_REG_W-1:0]  reg_idx;
    logic [DEFAULT_DATA_W-1:0] data;
  } entry_t;

  // Packs a register index and data word into one storage word.
  function automatic entry_t make_entry(input logic [DEFAULT_REG_W-1:0] reg_idx,
                                        input logic [DEFAULT_DATA_W-1:0] data);
    entry_t e;
    e.reg_idx = reg_idx;
    e.data    = data;
    return e;
  endfunction

endpackage

// File: rtl/wb_trace_mem.sv
// wb_trace_mem
//   Storage array for the writeback trace FIFO. One synchronous write port
//   and one asynchronous (combinational) read port. The array has no reset;
//   the FIFO pointers alone decide which words are meaningful.
//
// Ports
//   Clock  : write clock, rising edge
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address
//   rdata  : read data, combinational from raddr
module wb_trace_mem
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 38
) (
  input  logic                     Clock,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge Clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/wb_trace_fifo.sv
// wb_trace_fifo
//   First-word-fall-through FIFO that captures register writebacks from the
//   MEM/WB stage of a pipeline core for tracing. Writes to register 0 are
//   filtered out. When full, a push without a simultaneous pop is dropped
//   and the sticky overflow flag is raised.
//
// Ports
//   Clock    : single clock, rising edge
//   Reset    : asynchronous, active-high reset
//   regIn    : destination register from MEM/WB
//   dataIn   : writeback data from MEM/WB
//   weIn     : register-write strobe for this cycle
//   outReady : consumer accepts the head entry
//   outValid : head entry valid (count != 0)
//   outReg   : head entry register index (0 when empty)
//   outData  : head entry data (0 when empty)
//   count    : number of stored entries
//   overflow : sticky, set when an entry was dropped
//   ovfCount : 16-bit saturating dropped-entry counter, only present when
//              the macro WB_TRACE_OVF_CNT_EN is defined
module wb_trace_fifo
  import wb_trace_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int REG_W  = DEFAULT_REG_W,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic [REG_W-1:0]         regIn,
  input  logic [DATA_W-1:0]        dataIn,
  input  logic                     weIn,
  input  logic                     outReady,
  output logic                     outValid,
  output logic [REG_W-1:0]         outReg,
  output logic [DATA_W-1:0]        outData,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
`ifdef WB_TRACE_OVF_CNT_EN
  ,
  output logic [15:0]              ovfCount
`endif
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = REG_W + DATA_W;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count_q;
  logic               overflow_q;
  logic [ENTRY_W-1:0] head_word;

  logic push_req;
  logic empty;
  logic full;
  logic do_push;
  logic do_pop;
  logic drop;

  // A pop is only possible when something is stored, so a push into an
  // empty FIFO is never popped on the same edge. When full, a push is only
  // accepted if the head leaves on the same edge; otherwise it is dropped.
  always_comb begin
    push_req = weIn && (regIn != '0);
    empty    = (count_q == '0);
    full     = (count_q == FULL_COUNT);
    do_pop   = !empty && outReady;
    do_push  = push_req && (!full || do_pop);
    drop     = push_req && full && !do_pop;
  end

  wb_trace_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_mem (
    .Clock (Clock),
    .we    (do_push),
    .waddr (wr_ptr),
    .wdata ({regIn, dataIn}),
    .raddr (rd_ptr),
    .rdata (head_word)
  );

  // The storage array is never reset, so the head is masked to zero while
  // empty to keep the outputs clean after reset.
  always_comb begin
    outValid = !empty;
    outReg   = '0;
    outData  = '0;
    if (!empty) begin
      outReg  = head_word[ENTRY_W-1:DATA_W];
      outData = head_word[DATA_W-1:0];
    end
  end

  assign count    = count_q;
  assign overflow = overflow_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Occupancy only moves when exactly one of push/pop happens.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky until reset so a trace consumer can tell the stream has a gap.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end
  end

`ifdef WB_TRACE_OVF_CNT_EN
  logic [15:0] ovf_count_q;

  // Counts every dropped entry, holding at the ceiling instead of wrapping.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ovf_count_q <= '0;
    end else if (drop && (ovf_count_q != OVF_CNT_MAX)) begin
      ovf_count_q <= ovf_count_q + 16'd1;
    end
  end

  assign ovfCount = ovf_count_q;
`endif

endmodule

// File: doc/wb_trace_fifo.md
WB_TRACE_FIFO -- requirements
Module: wb_trace_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning entry count; power of two, 2..64.
REQ-002 SHALL have parameter REG_W, default 6, meaning register-index width.
REQ-003 SHALL have parameter DATA_W, default 32, meaning writeback data width.
REQ-004 SHALL have port Clock  input  1  meaning the single clock; all state on rising edge.
REQ-005 SHALL have port Reset  input  1  meaning asynchronous, active-high reset.
REQ-006 SHALL have port regIn  input  REG_W  meaning the MEM/WB destination register from the pipeline core.
REQ-007 SHALL have port dataIn  input  DATA_W  meaning the writeback data from the pipeline core.
REQ-008 SHALL have port weIn  input  1  meaning the writeback register-write strobe for this cycle.
REQ-009 SHALL have port outReady  input  1  meaning the consumer accepts the head entry.
REQ-010 SHALL have port outValid  output  1  meaning the head entry is valid.
REQ-011 SHALL have port outReg  output  REG_W  meaning the head entry register index.
REQ-012 SHALL have port outData  output  DATA_W  meaning the head entry data.
REQ-013 SHALL have port count  output  $clog2(DEPTH)+1  meaning the number of stored entries.
REQ-014 SHALL have port overflow  output  1  meaning a sticky flag set when an entry was dropped.

Function
REQ-015 SHALL push {regIn,dataIn} on a rising edge when weIn=1 and regIn!=0; writes to register 0 SHALL be ignored.
REQ-016 SHALL pop on a rising edge when outValid=1 and outReady=1.
REQ-017 SHALL present first-word-fall-through output: outValid = (count!=0); outReg/outData SHALL equal the oldest entry combinationally from storage.
REQ-018 SHALL make a pushed entry visible at the outputs in the cycle after the push edge (latency 1).
REQ-019 SHALL, on push and pop in the same edge with 0<count<DEPTH, keep count unchanged and preserve FIFO order.
REQ-020 SHALL, when full, accept push and pop in the same edge: the head is popped, the new entry is appended, and count stays DEPTH.
REQ-021 SHALL, when full with push and no pop, drop the new entry, leave storage unchanged, and set overflow=1 until reset.
REQ-022 SHALL, when empty, ignore outReady; a push with outReady=1 SHALL NOT be popped in the same edge.
REQ-023 SHALL wrap read and write pointers modulo DEPTH with no lost or duplicated entries.
REQ-024 SHALL hold outReg/outData stable while outValid=1 and outReady=0.

Reset
REQ-025 SHALL, on Reset=1 (async), force count=0, outValid=0, overflow=0, and both pointers to 0, with outReg=0 and outData=0.
REQ-026 SHALL discard all stored entries on reset mid-operation; the first push after deassertion SHALL become the head.
REQ-027 SHALL NOT require storage-array contents to be reset.

Configuration
REQ-028 SHALL support macro WB_TRACE_OVF_CNT_EN.
REQ-029 SHALL, with WB_TRACE_OVF_CNT_EN defined, add output ovfCount (16 bits), which increments per dropped entry, saturates at 16'hFFFF, and resets to 0.
REQ-030 SHALL, without WB_TRACE_OVF_CNT_EN, have no ovfCount port or counter; all other behaviour SHALL be identical.

Structure
REQ-031 SHALL take the default DEPTH/REG_W/DATA_W constants and the entry typedef {reg, data} from shared package wb_trace_pkg.
REQ-032 SHALL place the storage array in sub-module wb_trace_mem, which has 1 write port and 1 asynchronous read port and no reset.
REQ-033 SHALL keep pointers, count and flags in wb_trace_fifo.

Verification
REQ-034 SHALL verify basic order: push (5,0x11),(6,0x22) with outReady=0 -> count=2, head=(5,0x11); raise outReady for 2 cycles -> pops 0x11 then 0x22, then outValid=0.
REQ-035 SHALL verify the register-0 filter: weIn=1, regIn=0, dataIn=0xDEAD -> count stays 0, outValid=0.
REQ-036 SHALL verify overflow: DEPTH=8; push 9 entries with outReady=0 -> count=8, overflow=1, ovfCount=1 (macro on); drain -> first 8 entries pop in order.
REQ-037 SHALL verify push and pop while full: full, weIn=1 and outReady=1 for 3 cycles -> count=8, overflow=0, order preserved across pointer wrap.
REQ-038 SHALL verify async reset: 4 entries stored, Reset pulse mid-cycle -> count=0, outValid=0, overflow=0 immediately; next push (7,0x77) becomes head one cycle later.
REQ-039 SHALL verify saturation: force 65537 drops with the macro on -> ovfCount=0xFFFF.
